// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use / taken-branch hazard control for the 5-stage RV32I pipeline
module hazard_scoreboard #(
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_mem_read_en,
  input  logic [4:0]       ex_rd_addr,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             branch_taken,
  output logic             if_pc_write_en,
  output logic             id_ex_reg_en,
  output logic             id_bubble_sel,
  output logic             ex_bubble_sel,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int PipeN = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  localparam int FcntW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic             rs1Used;
  logic             rs2Used;
  logic             exLoadQual;
  logic             hazard;
  logic             stallCycle;
  logic [PipeN-1:0] pipeValid;
  logic [4:0]       pipeRd [PipeN];
  logic [FcntW-1:0] fcnt;

  always_comb begin
    rs1Used    = !(id_opcode inside {OpLui, OpAuipc, OpJal}) && (id_rs1_addr != 5'd0);
    rs2Used    = (id_opcode inside {OpRType, OpStore, OpBranch}) && (id_rs2_addr != 5'd0);
    exLoadQual = ex_valid && ex_mem_read_en && (ex_rd_addr != 5'd0) && !branch_taken;
    hazard     = exLoadQual && ((rs1Used && (id_rs1_addr == ex_rd_addr)) ||
                                (rs2Used && (id_rs2_addr == ex_rd_addr)));
    for (int i = 0; i < PipeN; i++) begin
      if (pipeValid[i] && ((rs1Used && (id_rs1_addr == pipeRd[i])) ||
                           (rs2Used && (id_rs2_addr == pipeRd[i]))))
        hazard = 1'b1;
    end
  end

  // Loads age every cycle regardless of stalls; only IF/ID is frozen by a stall.
  if (LOAD_LAT > 1) begin : gPipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipeValid <= '0;
      end else begin
        pipeValid[0] <= exLoadQual;
        for (int i = 1; i < PipeN; i++) pipeValid[i] <= pipeValid[i-1];
      end
      pipeRd[0] <= ex_rd_addr;
      for (int i = 1; i < PipeN; i++) pipeRd[i] <= pipeRd[i-1];
    end
  end else begin : gNoPipe
    assign pipeValid = '0;
    assign pipeRd[0] = 5'd0;
  end

  // A branch inside an open window reloads the count rather than extending it additively.
  always_ff @(posedge clk) begin
    if (!rst_n)                fcnt <= '0;
    else if (branch_taken)     fcnt <= FcntW'(FLUSH_DEPTH - 1);
    else if (fcnt != '0)       fcnt <= fcnt - FcntW'(1);
  end

  always_comb begin
    if_pc_write_en = 1'b1;
    id_ex_reg_en   = 1'b1;
    id_bubble_sel  = 1'b0;
    ex_bubble_sel  = 1'b0;
    if_flush       = 1'b0;
    stallCycle     = 1'b0;
    if (branch_taken) begin
      id_bubble_sel = 1'b1;
      ex_bubble_sel = 1'b1;
      if_flush      = 1'b1;
    end else if (fcnt != '0) begin
      id_bubble_sel = 1'b1;
      if_flush      = 1'b1;
    end else if (hazard) begin
      if_pc_write_en = 1'b0;
      id_ex_reg_en   = 1'b0;
      id_bubble_sel  = 1'b1;
      stallCycle     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stallCycle && (stall_count != '1))   stall_count <= stall_count + CNT_W'(1);
      if (branch_taken && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
